// File: rtl/chunked_seq_adder.sv
`default_nettype none
// =============================================================================
// chunked_seq_adder : WIDTH-bit add/subtract computed CHUNK bits per clock,
//                     with valid/ready handshakes on operands and result.
// Revision 1.0
// =============================================================================
module chunked_seq_adder #(
  parameter int WIDTH = 9,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carryout,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [CHUNK:0]     chunk_total;
  logic               last;

  // Operands shift right one chunk per cycle, so the active chunk is always
  // the low CHUNK bits; on the last chunk those hold the original MSBs.
  assign chunk_total = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry};
  assign last        = (idx == IDX_W'(N - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last)      next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      Sum      <= '0;
      Carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= A;
            b_sh  <= B ^ {WIDTH{sub}};
            carry <= sub | Cin;
            idx   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          carry <= chunk_total[CHUNK];
          idx   <= idx + IDX_W'(1);
          // New chunk enters at the top; after N chunks each slice is in place.
          Sum   <= WIDTH'({chunk_total[CHUNK-1:0], Sum} >> CHUNK);
          if (last) begin
            Carryout <= chunk_total[CHUNK];
            overflow <= (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                        (chunk_total[CHUNK-1] != a_sh[CHUNK-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chunked_seq_adder.sv
`default_nettype none
// tb_chunked_seq_adder : directed + randomized scoreboard bench for the default
// configuration, plus randomized sweeps of CHUNK=1, CHUNK=WIDTH and 16/4.
module tb_chunked_seq_adder;

  typedef struct {
    longint sum;
    bit     co;
    bit     ov;
    longint acc;
  } exp_t;

  int     n_cmp = 0;
  int     n_fail = 0;
  longint cyc = 0;
  bit     sweep_done [3];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic void model(input int w, input longint a, input longint b,
                                input bit cin, input bit s, output longint sum,
                                output bit co, output bit ov);
    longint m, sa, sb, r, t;
    m  = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (s) begin
      sum = (a - b + m) % m;
      co  = (a >= b);
      r   = sa - sb;
    end else begin
      t   = a + b + longint'(cin);
      sum = t % m;
      co  = (t >= m);
      r   = sa + sb + longint'(cin);
    end
    ov = (r > m / 2 - 1) || (r < -(m / 2));
  endfunction

  // ---------------------------------------------------------------- default DUT
  logic       rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [8:0] a, b, sum;
  bit         rand_rdy = 1'b0;
  exp_t       q0[$];
  exp_t       e0;
  bit         prev0 = 1'b0;

  chunked_seq_adder #(.WIDTH(9), .CHUNK(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .Sum(sum), .Carryout(cout), .overflow(ovf)
  );

  always @(negedge clk) begin
    if (!rst_n) prev0 = 1'b0;
    else begin
      if (out_valid && !prev0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL d0_unexpected_out_valid: got out_valid=1, expected no result (cycle %0d)", cyc);
        end else begin
          e0 = q0.pop_front();
          chk("d0_latency", cyc - e0.acc, 3);
          chk("d0_sum", longint'(sum), e0.sum);
          chk("d0_carryout", longint'(cout), longint'(e0.co));
          chk("d0_overflow", longint'(ovf), longint'(e0.ov));
        end
      end
      prev0 = out_valid;
    end
  end

  task automatic issue0(input logic [8:0] av, input logic [8:0] bv, input bit c,
                        input bit s, input longint es, input bit eco, input bit eov,
                        input bit push);
    int t = 0;
    @(negedge clk);
    a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      if (rand_rdy) out_ready = 1'($urandom);
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL d0_accept_timeout: got in_ready=0, expected 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    if (push) q0.push_back('{es, eco, eov, cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
    a = 9'($urandom); b = 9'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic drain0();
    int t = 0;
    out_ready = 1'b1;
    while ((q0.size() != 0 || !in_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("d0_drain_pending", q0.size(), 0);
  endtask

  // ---------------------------------------------------------------- sweeps
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W  = (g == 2) ? 16 : 9;
    localparam int C  = (g == 0) ? 1 : ((g == 1) ? 9 : 4);
    localparam int NN = W / C;

    logic         rn, iv, ir, ci, sb, ovd, orr, co, ov;
    logic [W-1:0] av, bv, sm;
    exp_t         q[$];
    exp_t         e;
    bit           prev = 1'b0;
    longint       es;
    bit           eco, eov, ok;
    int           t;

    chunked_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir),
      .A(av), .B(bv), .Cin(ci), .sub(sb), .out_valid(ovd),
      .out_ready(orr), .Sum(sm), .Carryout(co), .overflow(ov)
    );

    always @(negedge clk) begin
      if (!rn) prev = 1'b0;
      else begin
        if (ovd && !prev) begin
          if (q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sw%0d_unexpected_out_valid: got out_valid=1, expected no result", g);
          end else begin
            e = q.pop_front();
            chk($sformatf("sw%0d_latency", g), cyc - e.acc, NN);
            chk($sformatf("sw%0d_sum", g), longint'(sm), e.sum);
            chk($sformatf("sw%0d_carryout", g), longint'(co), longint'(e.co));
            chk($sformatf("sw%0d_overflow", g), longint'(ov), longint'(e.ov));
          end
        end
        prev = ovd;
      end
    end

    initial begin
      rn = 1'b0; iv = 1'b0; orr = 1'b0; av = '0; bv = '0; ci = 1'b0; sb = 1'b0;
      ok = 1'b1;
      repeat (2) @(negedge clk);
      rn = 1'b1;
      for (int i = 0; i < 1000 && ok; i++) begin
        av = W'($urandom); bv = W'($urandom); ci = 1'($urandom); sb = 1'($urandom);
        iv = 1'b1;
        model(W, longint'(av), longint'(bv), ci, sb, es, eco, eov);
        t = 0;
        while (!ir && t < 200) begin
          orr = 1'($urandom);
          @(negedge clk);
          t++;
        end
        if (!ir) begin
          n_cmp++; n_fail++;
          $display("FAIL sw%0d_accept_timeout: got in_ready=0, expected 1 within 200 cycles", g);
          ok = 1'b0;
        end else begin
          q.push_back('{es, eco, eov, cyc + 1});
          @(negedge clk);
          iv = 1'b0; av = W'($urandom); bv = W'($urandom); ci = 1'($urandom); sb = 1'($urandom);
          repeat ($urandom_range(0, 2)) begin
            orr = 1'($urandom);
            @(negedge clk);
          end
        end
      end
      orr = 1'b1;
      t = 0;
      while ((q.size() != 0 || !ir) && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("sw%0d_drain_pending", g), q.size(), 0);
      sweep_done[g] = 1'b1;
    end
  end

  // ---------------------------------------------------------------- main
  initial begin
    longint es;
    bit     eco, eov;
    logic [8:0] ra, rb;
    bit     rc, rs;
    int     t;

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a = 9'h1AB; b = 9'h0CD; cin = 1'b1; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sum", longint'(sum), 0);
    chk("rst_carryout", longint'(cout), 0);
    chk("rst_overflow", longint'(ovf), 0);
    in_valid = 1'b0; rst_n = 1'b1; out_ready = 1'b1;

    issue0(9'h1FF, 9'h001, 1'b0, 1'b0, 'h000, 1'b1, 1'b0, 1'b1);
    issue0(9'd5,   9'd7,   1'b1, 1'b1, 'h1FE, 1'b0, 1'b0, 1'b1);
    issue0(9'h0FF, 9'h001, 1'b0, 1'b0, 'h100, 1'b0, 1'b1, 1'b1);
    drain0();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    ra = 9'($urandom); rb = 9'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    model(9, longint'(ra), longint'(rb), rc, rs, es, eco, eov);
    issue0(ra, rb, rc, rs, es, eco, eov, 1'b1);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid_rise", longint'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid_hold", longint'(out_valid), 1);
      chk("bp_sum_hold", longint'(sum), es);
      chk("bp_in_ready_low", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_after_take", longint'(in_ready), 1);
    chk("bp_out_valid_after_take", longint'(out_valid), 0);

    // Reset during RUN abandons the operation.
    issue0(9'h155, 9'h0AA, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_sum", longint'(sum), 0);
    chk("midrst_carryout", longint'(cout), 0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_result", longint'(out_valid), 0);
    end

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 9'($urandom); rb = 9'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i < 8) begin
        ra = (i[0]) ? 9'h100 : 9'h0FF;
        rb = (i[1]) ? 9'h1FF : 9'h100;
      end
      model(9, longint'(ra), longint'(rb), rc, rs, es, eco, eov);
      issue0(ra, rb, rc, rs, es, eco, eov, 1'b1);
    end
    rand_rdy = 1'b0;
    drain0();

    t = 0;
    while (!(sweep_done[0] && sweep_done[1] && sweep_done[2]) && t < 80000) begin
      @(negedge clk);
      t++;
    end
    if (!(sweep_done[0] && sweep_done[1] && sweep_done[2])) begin
      n_cmp++; n_fail++;
      $display("FAIL sweep_timeout: got sweeps unfinished, expected all done within 80000 cycles");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
